cm_secret_responder: RTL and testbench

//  Responder side of the CM byte bus: the peer of the guessing FSM, one bus-interface hop away.

---
 rtl/cm_secret_responder_pkg.sv | 31 +++
 rtl/cm_bitserial_cmp.sv | 61 ++++++
 rtl/cm_secret_responder.sv | 130 +++++++++++++
 tb/tb_cm_secret_responder.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cm_secret_responder_pkg.sv
// Shared definitions for the CM byte-bus responder: protocol bytes, FSM encoding, sizing helpers.
package cm_secret_responder_pkg;

    localparam logic [7:0] BUS_READY = 8'hCC;
    localparam logic [7:0] BUS_YES   = 8'hA5;
    localparam logic [7:0] BUS_NO    = 8'h5A;

    typedef enum logic [2:0] {
        ST_ANNOUNCE   = 3'd0,
        ST_WAIT_GUESS = 3'd1,
        ST_COMPARE    = 3'd2,
        ST_REPLY      = 3'd3,
        ST_LOCKED     = 3'd4
    } state_t;

    // One guess attempt as latched at acceptance time.
    typedef struct packed {
        logic [7:0] guess;
        logic [7:0] key;
    } attempt_t;

    // Counter width able to index 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 32'd2) ? 32'd1 : $clog2(n);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/cm_bitserial_cmp.sv
// Early-exit, MSB-first bit-serial comparator; each bit takes BIT_DELAY cycles.
module cm_bitserial_cmp
    import cm_secret_responder_pkg::*;
#(
    parameter int unsigned BIT_DELAY = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] guess,
    input  logic [7:0] key,
    output logic       done_c,
    output logic       match_c,
    output logic [3:0] nbits_c
);

    localparam int unsigned DW = cnt_width(BIT_DELAY);
    localparam logic [DW-1:0] DLAST = DW'(BIT_DELAY - 1);

    attempt_t      q;
    logic          busy;
    logic [2:0]    idx;
    logic [DW-1:0] dcnt;
    logic          bit_eq;
    logic          at_last;

    // Decision happens on the final cycle of each bit's delay window.
    always_comb begin
        bit_eq  = (q.guess[idx] == q.key[idx]);
        at_last = busy && (dcnt == DLAST);
        done_c  = at_last && (!bit_eq || (idx == 3'd0));
        match_c = bit_eq;
        nbits_c = 4'(4'd8 - {1'b0, idx});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            busy <= 1'b0;
            idx  <= 3'd7;
            dcnt <= '0;
        end else if (load) begin
            q    <= '{guess: guess, key: key};
            busy <= 1'b1;
            idx  <= 3'd7;
            dcnt <= '0;
        end else if (busy) begin
            if (at_last) begin
                dcnt <= '0;
                if (done_c) begin
                    busy <= 1'b0;
                end else begin
                    idx <= idx - 3'd1;
                end
            end else begin
                dcnt <= dcnt + DW'(1);
            end
        end
    end

endmodule

// File: rtl/cm_secret_responder.sv
// Responder FSM: announces readiness, accepts guesses, sequences the compare and drives the reply.
module cm_secret_responder
    import cm_secret_responder_pkg::*;
#(
    parameter int unsigned BIT_DELAY    = 4,
    parameter int unsigned ANNOUNCE_CYC = 8,
    parameter int unsigned REPLY_CYC    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  secret,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_en,
    output logic        unlocked,
    output logic [15:0] attempts,
    output logic [3:0]  last_bits
);

    localparam int unsigned PW = cnt_width(max_u(ANNOUNCE_CYC, REPLY_CYC) + 1);
    localparam logic [PW-1:0] ANN_END = PW'(ANNOUNCE_CYC);
    localparam logic [PW-1:0] REP_END = PW'(REPLY_CYC - 1);

    state_t        state, state_d;
    logic [PW-1:0] cnt, cnt_d;
    logic          hit, hit_d;
    logic [15:0]   attempts_d;
    logic [3:0]    last_bits_d;
    logic [7:0]    tx_data_d;
    logic          tx_en_d;
    logic          unlocked_d;
    logic          accept;
    logic          done_c;
    logic          match_c;
    logic [3:0]    nbits_c;

    cm_bitserial_cmp #(
        .BIT_DELAY (BIT_DELAY)
    ) u_cmp (
        .clk     (clk),
        .rst     (rst),
        .load    (accept),
        .guess   (rx_data),
        .key     (secret),
        .done_c  (done_c),
        .match_c (match_c),
        .nbits_c (nbits_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_ANNOUNCE;
            cnt       <= '0;
            hit       <= 1'b0;
            attempts  <= '0;
            last_bits <= '0;
            tx_data   <= '0;
            tx_en     <= 1'b0;
            unlocked  <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            hit       <= hit_d;
            attempts  <= attempts_d;
            last_bits <= last_bits_d;
            tx_data   <= tx_data_d;
            tx_en     <= tx_en_d;
            unlocked  <= unlocked_d;
        end
    end

    // Outputs are registered from the next state so tx_en rises on the edge the state is entered.
    always_comb begin
        state_d     = state;
        cnt_d       = cnt + PW'(1);
        hit_d       = hit;
        attempts_d  = attempts;
        last_bits_d = last_bits;
        accept      = 1'b0;

        case (state)
            ST_ANNOUNCE: begin
                if (cnt == ANN_END) begin
                    state_d = ST_WAIT_GUESS;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_GUESS: begin
                cnt_d = '0;
                if (rx_valid) begin
                    accept     = 1'b1;
                    state_d    = ST_COMPARE;
                    attempts_d = (attempts == 16'hFFFF) ? attempts : attempts + 16'd1;
                end
            end
            ST_COMPARE: begin
                cnt_d = '0;
                if (done_c) begin
                    state_d     = ST_REPLY;
                    hit_d       = match_c;
                    last_bits_d = nbits_c;
                end
            end
            ST_REPLY: begin
                if (cnt == REP_END) begin
                    cnt_d   = '0;
                    state_d = hit ? ST_LOCKED : ST_WAIT_GUESS;
                end
            end
            ST_LOCKED: begin
                cnt_d = '0;
            end
            default: begin
                state_d = ST_ANNOUNCE;
                cnt_d   = '0;
            end
        endcase

        tx_en_d    = (state_d == ST_ANNOUNCE) || (state_d == ST_REPLY);
        unlocked_d = (state_d == ST_LOCKED);
        tx_data_d  = 8'h00;
        if (state_d == ST_ANNOUNCE) begin
            tx_data_d = BUS_READY;
        end else if (state_d == ST_REPLY) begin
            tx_data_d = hit_d ? BUS_YES : BUS_NO;
        end
    end

endmodule

// File: tb/tb_cm_secret_responder.sv
// Directed self-checking bench for cm_secret_responder at default parameters, secret=0x5C.
module tb_cm_secret_responder;
    import cm_secret_responder_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  secret = 8'h5C;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_en;
    logic        unlocked;
    logic [15:0] attempts;
    logic [3:0]  last_bits;

    int checks = 0;
    int errors = 0;

    cm_secret_responder dut (
        .clk       (clk),
        .rst       (rst),
        .secret    (secret),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_en     (tx_en),
        .unlocked  (unlocked),
        .attempts  (attempts),
        .last_bits (last_bits)
    );

    always #5 clk = ~clk;

    // Counts consecutive 0xCC cycles; optionally pokes rx_valid in the middle of the announce.
    task automatic measure_announce(input bit poke, output int len);
        len = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
            if (tx_en && tx_data === BUS_READY) begin
                len++;
                if (poke && len == 3) begin
                    rx_valid = 1'b1;
                    rx_data  = 8'h5C;
                end
            end else if (len > 0) begin
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    // Sends one guess, measures latency to first tx_en cycle and reply length.
    task automatic do_guess(input logic [7:0] g, input int poke_at, input bit poke_reply,
                            output int lat, output int dur, output logic [7:0] rb);
        lat = -1; dur = 0; rb = 8'h00;
        rx_data = g; rx_valid = 1'b1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            rx_valid = 1'b0;
            if (tx_en) begin
                lat = n; rb = tx_data;
                break;
            end
            if (n == poke_at) begin
                rx_valid = 1'b1;
                rx_data  = 8'h5C;
                secret   = 8'hA3;
            end
        end
        if (lat > 0) begin
            for (int n = 0; n < 40; n++) begin
                if (!(tx_en && tx_data === rb)) break;
                dur++;
                rx_valid = poke_reply && (n == 2);
                @(posedge clk); #1;
                rx_valid = 1'b0;
            end
        end
    endtask

    task automatic watch_quiet(output int hits);
        hits = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (tx_en || tx_data !== 8'h00) hits++;
        end
    endtask

    task automatic test_reset;
        int len;
        #3 rst = 1'b1;
        #1;
        checks++; if (tx_en !== 1'b0) begin errors++; $display("FAIL reset_tx_en: got %b expected 0", tx_en); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
        checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL reset_unlocked: got %b expected 0", unlocked); end
        checks++; if (attempts !== 16'd0) begin errors++; $display("FAIL reset_attempts: got %0d expected 0", attempts); end
        checks++; if (last_bits !== 4'd0) begin errors++; $display("FAIL reset_last_bits: got %0d expected 0", last_bits); end
        @(posedge clk); #1;
        rst = 1'b0;
        measure_announce(1'b0, len);
        checks++; if (len != 8) begin errors++; $display("FAIL announce_len: got %0d expected 8", len); end
        checks++; if (tx_en !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL announce_end: got en=%b data=%h expected en=0 data=00", tx_en, tx_data); end
    endtask

    task automatic test_miss_early;
        int lat, dur; logic [7:0] rb;
        do_guess(8'h00, 0, 1'b0, lat, dur, rb);
        checks++; if (lat != 9) begin errors++; $display("FAIL g00_latency: got %0d expected 9", lat); end
        checks++; if (rb !== BUS_NO) begin errors++; $display("FAIL g00_byte: got %h expected 5a", rb); end
        checks++; if (dur != 8) begin errors++; $display("FAIL g00_reply_len: got %0d expected 8", dur); end
        checks++; if (last_bits !== 4'd2) begin errors++; $display("FAIL g00_last_bits: got %0d expected 2", last_bits); end
        checks++; if (attempts !== 16'd1) begin errors++; $display("FAIL g00_attempts: got %0d expected 1", attempts); end
        checks++; if (unlocked !== 1'b0) begin errors++; $display("FAIL g00_unlocked: got %b expected 0", unlocked); end
    endtask

    task automatic test_miss_lsb_msb;
        int lat, dur; logic [7:0] rb;
        do_guess(8'h5D, 0, 1'b0, lat, dur, rb);
        checks++; if (lat != 33) begin errors++; $display("FAIL g5d_latency: got %0d expected 33", lat); end
        checks++; if (rb !== BUS_NO) begin errors++; $display("FAIL g5d_byte: got %h expected 5a", rb); end
        checks++; if (last_bits !== 4'd8) begin errors++; $display("FAIL g5d_last_bits: got %0d expected 8", last_bits); end
        do_guess(8'hDC, 0, 1'b0, lat, dur, rb);
        checks++; if (lat != 5) begin errors++; $display("FAIL gdc_latency: got %0d expected 5", lat); end
        checks++; if (dur != 8) begin errors++; $display("FAIL gdc_reply_len: got %0d expected 8", dur); end
        checks++; if (last_bits !== 4'd1) begin errors++; $display("FAIL gdc_last_bits: got %0d expected 1", last_bits); end
        checks++; if (attempts !== 16'd3) begin errors++; $display("FAIL gdc_attempts: got %0d expected 3", attempts); end
    endtask

    task automatic test_ignored;
        int lat, dur, hits; logic [7:0] rb;
        // 0x50 vs 0x5C: first mismatch at bit 3, so k=5
        do_guess(8'h50, 3, 1'b1, lat, dur, rb);
        secret = 8'h5C;
        checks++; if (lat != 21) begin errors++; $display("FAIL g50_latency: got %0d expected 21", lat); end
        checks++; if (rb !== BUS_NO) begin errors++; $display("FAIL g50_byte: got %h expected 5a", rb); end
        checks++; if (dur != 8) begin errors++; $display("FAIL g50_reply_len: got %0d expected 8", dur); end
        checks++; if (last_bits !== 4'd5) begin errors++; $display("FAIL g50_last_bits: got %0d expected 5", last_bits); end
        checks++; if (attempts !== 16'd4) begin errors++; $display("FAIL g50_attempts: got %0d expected 4", attempts); end
        watch_quiet(hits);
        checks++; if (hits != 0) begin errors++; $display("FAIL ignored_rx_quiet: got %0d tx cycles expected 0", hits); end
    endtask

    task automatic test_rst_mid_compare;
        int len, hits;
        rx_data = 8'h5D; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checks++; if (attempts !== 16'd5) begin errors++; $display("FAIL pre_rst_attempts: got %0d expected 5", attempts); end
        rst = 1'b1;
        #1;
        checks++; if (tx_en !== 1'b0 || tx_data !== 8'h00) begin errors++; $display("FAIL midrst_tx: got en=%b data=%h expected 0/00", tx_en, tx_data); end
        checks++; if (attempts !== 16'd0 || last_bits !== 4'd0) begin errors++; $display("FAIL midrst_counters: got attempts=%0d last_bits=%0d expected 0/0", attempts, last_bits); end
        @(posedge clk); #1;
        rst = 1'b0;
        measure_announce(1'b1, len);
        checks++; if (len != 8) begin errors++; $display("FAIL midrst_announce_len: got %0d expected 8", len); end
        watch_quiet(hits);
        checks++; if (hits != 0) begin errors++; $display("FAIL announce_rx_quiet: got %0d tx cycles expected 0", hits); end
        checks++; if (attempts !== 16'd0) begin errors++; $display("FAIL announce_rx_attempts: got %0d expected 0", attempts); end
    endtask

    task automatic test_unlock;
        int lat, dur, hits; logic [7:0] rb;
        do_guess(8'h5C, 0, 1'b0, lat, dur, rb);
        checks++; if (lat != 33) begin errors++; $display("FAIL g5c_latency: got %0d expected 33", lat); end
        checks++; if (rb !== BUS_YES) begin errors++; $display("FAIL g5c_byte: got %h expected a5", rb); end
        checks++; if (dur != 8) begin errors++; $display("FAIL g5c_reply_len: got %0d expected 8", dur); end
        checks++; if (unlocked !== 1'b1) begin errors++; $display("FAIL g5c_unlocked: got %b expected 1", unlocked); end
        checks++; if (last_bits !== 4'd8 || attempts !== 16'd1) begin errors++; $display("FAIL g5c_counters: got last_bits=%0d attempts=%0d expected 8/1", last_bits, attempts); end
        rx_data = 8'h00; rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
        watch_quiet(hits);
        checks++; if (hits != 0) begin errors++; $display("FAIL locked_quiet: got %0d tx cycles expected 0", hits); end
        checks++; if (attempts !== 16'd1 || unlocked !== 1'b1) begin errors++; $display("FAIL locked_state: got attempts=%0d unlocked=%b expected 1/1", attempts, unlocked); end
    endtask

    initial begin
        test_reset();
        test_miss_early();
        test_miss_lsb_msb();
        test_ignored();
        test_rst_mid_compare();
        test_unlock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
